// File: rtl/flag_stack_pkg.sv
// Shared types and constants for the C/Z flag shadow stack.
package flag_stack_pkg;

  localparam int unsigned FLAG_STACK_DEPTH_DEFAULT = 4;

  typedef struct packed {
    logic c;
    logic z;
  } flag_pair_t;

endpackage

// File: rtl/flag_stack_mem.sv
// DEPTH-entry flag-pair register file: synchronous write, asynchronous read.
module flag_stack_mem
  import flag_stack_pkg::*;
#(
  parameter int unsigned DEPTH = FLAG_STACK_DEPTH_DEFAULT,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  flag_pair_t    wdata,
  input  logic [AW-1:0] raddr,
  output flag_pair_t    rdata
);

  flag_pair_t mem_q [DEPTH];

  // Entries are don't-care after reset, so the array carries no reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/flag_shadow_stack.sv
// Interrupt save/restore LIFO for the C/Z flags with sticky overflow/underflow.
// Build option FLAG_SHADOW_STACK_WRAP_EN turns a full-push into a circular overwrite.
module flag_shadow_stack
  import flag_stack_pkg::*;
#(
  parameter int unsigned DEPTH = FLAG_STACK_DEPTH_DEFAULT,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic             c_in,
  input  logic             z_in,
  input  logic             clear_err,
  output logic             c_out,
  output logic             z_out,
  output logic             restore_valid,
  output logic [CNT_W-1:0] count,
  output logic             empty,
  output logic             full,
  output logic             overflow_err,
  output logic             underflow_err
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [CNT_W-1:0] count_q, count_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic             c_q, c_d, z_q, z_d;
  logic             rv_q, rv_d;
  logic             ovf_q, ovf_d, unf_q, unf_d;
  logic             mem_we;
  flag_pair_t       mem_wdata, mem_rdata;
  logic [PTR_W-1:0] mem_raddr;

  assign empty     = (count_q == CNT_W'(0));
  assign full      = (count_q == CNT_W'(DEPTH));
  assign mem_wdata = '{c: c_in, z: z_in};
  // ptr_q is the next free slot; the top of stack sits one below it (mod DEPTH).
  assign mem_raddr = ptr_q - PTR_W'(1);

  flag_stack_mem #(.DEPTH(DEPTH)) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (ptr_q),
    .wdata (mem_wdata),
    .raddr (mem_raddr),
    .rdata (mem_rdata)
  );

  always_comb begin
    count_d = count_q;
    ptr_d   = ptr_q;
    c_d     = c_q;
    z_d     = z_q;
    rv_d    = 1'b0;
    ovf_d   = ovf_q & ~clear_err;
    unf_d   = unf_q & ~clear_err;
    mem_we  = 1'b0;
    // Push wins over pop; a simultaneous pop is dropped without side effects.
    if (push) begin
      if (!full) begin
        mem_we  = 1'b1;
        ptr_d   = ptr_q + PTR_W'(1);
        count_d = count_q + CNT_W'(1);
      end else begin
`ifdef FLAG_SHADOW_STACK_WRAP_EN
        mem_we = 1'b1;
        ptr_d  = ptr_q + PTR_W'(1);
`else
        ovf_d  = 1'b1;
`endif
      end
    end else if (pop) begin
      if (!empty) begin
        c_d     = mem_rdata.c;
        z_d     = mem_rdata.z;
        rv_d    = 1'b1;
        ptr_d   = ptr_q - PTR_W'(1);
        count_d = count_q - CNT_W'(1);
      end else begin
        unf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
      ptr_q   <= '0;
      c_q     <= 1'b0;
      z_q     <= 1'b0;
      rv_q    <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      ptr_q   <= ptr_d;
      c_q     <= c_d;
      z_q     <= z_d;
      rv_q    <= rv_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  assign count         = count_q;
  assign c_out         = c_q;
  assign z_out         = z_q;
  assign restore_valid = rv_q;
  assign overflow_err  = ovf_q;
  assign underflow_err = unf_q;

endmodule

// File: tb/tb_flag_shadow_stack.sv
// Directed self-checking bench for flag_shadow_stack (DEPTH=4); honours FLAG_SHADOW_STACK_WRAP_EN.
module tb_flag_shadow_stack;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned CNT_W = 3;

  logic             clk = 1'b0;
  logic             reset, push, pop, c_in, z_in, clear_err;
  logic             c_out, z_out, restore_valid, empty, full;
  logic             overflow_err, underflow_err;
  logic [CNT_W-1:0] count;

  int checks = 0;
  int errors = 0;

  flag_shadow_stack #(.DEPTH(DEPTH)) dut (
    .clk           (clk),
    .reset         (reset),
    .push          (push),
    .pop           (pop),
    .c_in          (c_in),
    .z_in          (z_in),
    .clear_err     (clear_err),
    .c_out         (c_out),
    .z_out         (z_out),
    .restore_valid (restore_valid),
    .count         (count),
    .empty         (empty),
    .full          (full),
    .overflow_err  (overflow_err),
    .underflow_err (underflow_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Apply inputs, then sample 1 ns after the next rising edge.
  task automatic step(input logic p, input logic q, input logic [1:0] cz, input logic clr);
    push      = p;
    pop       = q;
    c_in      = cz[1];
    z_in      = cz[0];
    clear_err = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 2'b00, 1'b0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle();
    idle();
    reset = 1'b0;
  endtask

  task automatic chk_pop(input string tag, input logic [1:0] cz, input logic [CNT_W-1:0] cnt);
    step(1'b0, 1'b1, 2'b00, 1'b0);
    chk({tag, "_rv"}, 8'(restore_valid), 8'd1);
    chk({tag, "_cz"}, 8'({c_out, z_out}), 8'(cz));
    chk({tag, "_cnt"}, 8'(count), 8'(cnt));
  endtask

  initial begin
    reset = 1'b0; push = 1'b0; pop = 1'b0; c_in = 1'b0; z_in = 1'b0; clear_err = 1'b0;

    // 1: reset values, then two pushes and two LIFO pops
    do_reset();
    chk("rst_count", 8'(count), 8'd0);
    chk("rst_empty", 8'(empty), 8'd1);
    chk("rst_full", 8'(full), 8'd0);
    chk("rst_cz", 8'({c_out, z_out}), 8'd0);
    chk("rst_rv", 8'(restore_valid), 8'd0);
    chk("rst_err", 8'({overflow_err, underflow_err}), 8'd0);
    step(1'b1, 1'b0, 2'b10, 1'b0);
    step(1'b1, 1'b0, 2'b01, 1'b0);
    chk("t1_count2", 8'(count), 8'd2);
    chk("t1_rv_idle", 8'(restore_valid), 8'd0);
    chk_pop("t1_pop1", 2'b01, 3'd1);
    chk_pop("t1_pop2", 2'b10, 3'd0);
    chk("t1_empty", 8'(empty), 8'd1);
    idle();
    chk("t1_rv_drop", 8'(restore_valid), 8'd0);
    chk("t1_cz_hold", 8'({c_out, z_out}), 8'b10);

    // 2: underflow, then clear
    step(1'b0, 1'b1, 2'b00, 1'b0);
    chk("t2_rv", 8'(restore_valid), 8'd0);
    chk("t2_cz_hold", 8'({c_out, z_out}), 8'b10);
    chk("t2_count", 8'(count), 8'd0);
    chk("t2_unf", 8'(underflow_err), 8'd1);
    chk("t2_ovf", 8'(overflow_err), 8'd0);
    idle();
    chk("t2_unf_sticky", 8'(underflow_err), 8'd1);
    step(1'b0, 1'b0, 2'b00, 1'b1);
    chk("t2_unf_clr", 8'(underflow_err), 8'd0);

    // 3: five pushes into a depth-4 stack
    step(1'b1, 1'b0, 2'b00, 1'b0);
    step(1'b1, 1'b0, 2'b01, 1'b0);
    step(1'b1, 1'b0, 2'b10, 1'b0);
    step(1'b1, 1'b0, 2'b11, 1'b0);
    chk("t3_full4", 8'(full), 8'd1);
    chk("t3_ovf_pre", 8'(overflow_err), 8'd0);
    step(1'b1, 1'b0, 2'b01, 1'b0);
    chk("t3_count", 8'(count), 8'd4);
    chk("t3_full", 8'(full), 8'd1);
`ifdef FLAG_SHADOW_STACK_WRAP_EN
    chk("t3_ovf", 8'(overflow_err), 8'd0);
    chk_pop("t3_pop1", 2'b01, 3'd3);
    chk_pop("t3_pop2", 2'b11, 3'd2);
    chk_pop("t3_pop3", 2'b10, 3'd1);
    chk_pop("t3_pop4", 2'b01, 3'd0);
`else
    chk("t3_ovf", 8'(overflow_err), 8'd1);
    chk_pop("t3_pop1", 2'b11, 3'd3);
    chk_pop("t3_pop2", 2'b10, 3'd2);
    chk_pop("t3_pop3", 2'b01, 3'd1);
    chk_pop("t3_pop4", 2'b00, 3'd0);
`endif
    chk("t3_unf", 8'(underflow_err), 8'd0);
    step(1'b0, 1'b0, 2'b00, 1'b1);
    chk("t3_err_clr", 8'({overflow_err, underflow_err}), 8'd0);

    // 4: simultaneous push and pop -> push only
    step(1'b1, 1'b0, 2'b11, 1'b0);
    chk("t4_count1", 8'(count), 8'd1);
    step(1'b1, 1'b1, 2'b00, 1'b0);
    chk("t4_count2", 8'(count), 8'd2);
    chk("t4_rv", 8'(restore_valid), 8'd0);
    chk("t4_err", 8'({overflow_err, underflow_err}), 8'd0);
    chk_pop("t4_pop", 2'b00, 3'd1);
    chk_pop("t4_pop2", 2'b11, 3'd0);

    // 5: reset arriving together with a pop kills the restore
    step(1'b1, 1'b0, 2'b10, 1'b0);
    chk("t5_count1", 8'(count), 8'd1);
    reset = 1'b1;
    step(1'b0, 1'b1, 2'b00, 1'b0);
    reset = 1'b0;
    chk("t5_rv", 8'(restore_valid), 8'd0);
    chk("t5_count", 8'(count), 8'd0);
    chk("t5_empty", 8'(empty), 8'd1);
    chk("t5_cz", 8'({c_out, z_out}), 8'd0);
    idle();
    chk("t5_rv_after", 8'(restore_valid), 8'd0);

    // 6: clear_err coinciding with a new underflow leaves the bit set
    step(1'b0, 1'b1, 2'b00, 1'b1);
    chk("t6_unf_new", 8'(underflow_err), 8'd1);
    step(1'b0, 1'b1, 2'b00, 1'b1);
    chk("t6_unf_again", 8'(underflow_err), 8'd1);
    step(1'b0, 1'b0, 2'b00, 1'b1);
    chk("t6_unf_clr", 8'(underflow_err), 8'd0);

`ifndef FLAG_SHADOW_STACK_WRAP_EN
    // Overflow set in the same cycle as clear_err also sticks
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 2'b01, 1'b0);
    step(1'b1, 1'b0, 2'b10, 1'b1);
    chk("ovf_clr_same", 8'(overflow_err), 8'd1);
    chk("ovf_count", 8'(count), 8'd4);
    chk_pop("ovf_top", 2'b01, 3'd3);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
